// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared types, constants and quadrature decode for mouse_decoder
package mouse_pkg;

  localparam int unsigned MOUSE_WIDTH = 16;

  // Quadrature states in forward order: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ILLEGAL
  } step_e;

  // Position of a quadrature state along the forward cycle, so a step is a mod-4 difference
  function automatic logic [1:0] quad_phase(input logic [1:0] q);
    logic [1:0] phase;
    phase = 2'd0;
    case (q)
      Q00: phase = 2'd0;
      Q01: phase = 2'd1;
      Q11: phase = 2'd2;
      Q10: phase = 2'd3;
    endcase
    return phase;
  endfunction

  // +1 phase is forward, -1 is reverse, 0 is idle, 2 means both lines flipped at once
  function automatic step_e quad_step(input logic [1:0] prev_q, input logic [1:0] cur_q);
    logic [1:0] delta;
    step_e      step;
    delta = quad_phase(cur_q) - quad_phase(prev_q);
    case (delta)
      2'd0:    step = STEP_NONE;
      2'd1:    step = STEP_INC;
      2'd3:    step = STEP_DEC;
      default: step = STEP_ILLEGAL;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer plus stable-count debounce for a push input
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_,
  input  logic raw,
  output logic level
);

  // Counter must reach DEBOUNCE_CYCLES-1; sized with +1 so DEBOUNCE_CYCLES=1 still gets one bit
  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clock) begin
    if (reset_) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock) begin
    if (reset_) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mouse_decoder.sv
// rtl/mouse_decoder.sv - quadrature to clamped position plus debounced button
module mouse_decoder
  import mouse_pkg::*;
#(
  parameter int unsigned      WIDTH           = MOUSE_WIDTH,
  parameter logic [WIDTH-1:0] X_MAX           = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] X_RESET         = '0,
  parameter int unsigned      DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             button,
  output logic [WIDTH-1:0] mouse_x,
  output logic             mouse_pressed_,
  output logic             moved,
  output logic             error
);

  localparam logic [1:0] WARMUP_EDGES = 2'd2;

  logic [1:0]       q_sync1;
  logic [1:0]       q_sync2;
  logic [1:0]       prev;
  logic [1:0]       warm_cnt;
  logic             decode_en;
  step_e            step;
  logic [WIDTH-1:0] x_next;

  assign decode_en = (warm_cnt == WARMUP_EDGES);

  // Bring both quadrature lines into the clock domain together
  always_ff @(posedge clock) begin
    if (reset_) begin
      q_sync1 <= 2'b00;
      q_sync2 <= 2'b00;
    end else begin
      q_sync1 <= {quad_a, quad_b};
      q_sync2 <= q_sync1;
    end
  end

  // Warm-up counter and previous-state register; while warming, prev tracks the value
  // the synchronizer is about to present so a resting input never looks like a jump
  always_ff @(posedge clock) begin
    if (reset_) begin
      warm_cnt <= 2'd0;
      prev     <= 2'b00;
    end else begin
      if (!decode_en) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
      prev <= decode_en ? q_sync2 : q_sync1;
    end
  end

  // Decode this edge's step and apply it with saturation at 0 and X_MAX
  always_comb begin
    step   = STEP_NONE;
    x_next = mouse_x;
    if (decode_en) begin
      step = quad_step(prev, q_sync2);
    end
    case (step)
      STEP_INC: if (mouse_x < X_MAX) x_next = mouse_x + WIDTH'(1);
      STEP_DEC: if (mouse_x != '0)   x_next = mouse_x - WIDTH'(1);
      default:  ;
    endcase
  end

  // Position, move pulse and sticky error flag
  always_ff @(posedge clock) begin
    if (reset_) begin
      mouse_x <= X_RESET;
      moved   <= 1'b0;
      error   <= 1'b0;
    end else begin
      mouse_x <= x_next;
      moved   <= (x_next != mouse_x);
      if (step == STEP_ILLEGAL) begin
        error <= 1'b1;
      end
    end
  end

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clock (clock),
    .reset_(reset_),
    .raw   (button),
    .level (mouse_pressed_)
  );

endmodule

// File: tb/tb_mouse_decoder.sv
// tb/tb_mouse_decoder.sv - self-checking bench for mouse_decoder
`timescale 1ns/1ps
module tb_mouse_decoder;

  localparam int DC        = 4;
  localparam int SMALL_MAX = 3;
  localparam int BIG_MAX   = 65535;

  logic        clock  = 1'b0;
  logic        reset_ = 1'b1;
  logic        quad_a = 1'b0;
  logic        quad_b = 1'b0;
  logic        button = 1'b0;
  logic [15:0] mouse_x, mouse_x_s;
  logic        mouse_pressed_, pressed_s, moved, moved_s, error, error_s;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mouse_decoder #(.WIDTH(16), .X_MAX(16'hFFFF), .X_RESET(16'h0000), .DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock), .reset_(reset_), .quad_a(quad_a), .quad_b(quad_b), .button(button),
    .mouse_x(mouse_x), .mouse_pressed_(mouse_pressed_), .moved(moved), .error(error)
  );

  mouse_decoder #(.WIDTH(16), .X_MAX(16'd3), .X_RESET(16'd0), .DEBOUNCE_CYCLES(DC)) dut_s (
    .clock(clock), .reset_(reset_), .quad_a(quad_a), .quad_b(quad_b), .button(button),
    .mouse_x(mouse_x_s), .mouse_pressed_(pressed_s), .moved(moved_s), .error(error_s)
  );

  // Forward successor and reverse successor of a quadrature state
  function automatic logic [1:0] fwd_of(input logic [1:0] q);
    case (q)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] q);
    case (q)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Reference model: inputs reach the decoder two edges after sampling; position is an
  // integer clamped to [0, max]; button level flips after DC disagreeing synced samples
  int         m_n, m_x, m_xs;
  bit         m_moved, m_moved_s, m_err, m_pressed, m_flip;
  logic [1:0] m_prev, m_syn;
  logic       m_bsyn;
  logic [1:0] q_pipe[$];
  logic       b_pipe[$];
  logic       b_hist[$];

  always @(posedge clock) begin
    if (reset_ === 1'b1) begin
      m_n = 0; m_x = 0; m_xs = 0; m_moved = 0; m_moved_s = 0; m_err = 0; m_pressed = 0;
      m_prev = 2'b00;
      q_pipe = '{2'b00, 2'b00};
      b_pipe = '{1'b0, 1'b0};
      b_hist.delete();
    end else begin
      m_n++;
      m_moved = 0;
      m_moved_s = 0;
      q_pipe.push_back({quad_a, quad_b});
      m_syn = q_pipe.pop_front();
      if (m_n >= 4 && m_syn != m_prev) begin
        if (m_syn == fwd_of(m_prev)) begin
          if (m_x < BIG_MAX)   begin m_x++;  m_moved = 1;   end
          if (m_xs < SMALL_MAX) begin m_xs++; m_moved_s = 1; end
        end else if (m_syn == rev_of(m_prev)) begin
          if (m_x > 0)  begin m_x--;  m_moved = 1;   end
          if (m_xs > 0) begin m_xs--; m_moved_s = 1; end
        end else begin
          m_err = 1;
        end
      end
      m_prev = m_syn;
      b_pipe.push_back(button);
      m_bsyn = b_pipe.pop_front();
      b_hist.push_back(m_bsyn);
      if (b_hist.size() > DC) b_hist.delete(0);
      if (b_hist.size() == DC) begin
        m_flip = 1;
        foreach (b_hist[i]) if (b_hist[i] == m_pressed) m_flip = 0;
        if (m_flip) begin
          m_pressed = ~m_pressed;
          b_hist.delete();
        end
      end
    end
  end

  task automatic set_quad(input logic [1:0] q);
    quad_a = q[1];
    quad_b = q[0];
  endtask

  task automatic do_reset();
    reset_ = 1'b1;
    repeat (2) @(negedge clock);
    reset_ = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    set_quad(2'b00);
    button = 1'b0;
    reset_ = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (mouse_x !== 16'h0000) begin errors++; $display("FAIL reset_mouse_x: got %h expected 0000", mouse_x); end
    checks++; if (mouse_pressed_ !== 1'b0) begin errors++; $display("FAIL reset_pressed: got %b expected 0", mouse_pressed_); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved: got %b expected 0", moved); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (mouse_x_s !== 16'h0000) begin errors++; $display("FAIL reset_mouse_x_small: got %h expected 0000", mouse_x_s); end
    reset_ = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      checks++; if (error !== 1'b0 || moved !== 1'b0) begin errors++; $display("FAIL warmup_quiet: cycle %0d error=%b moved=%b expected 0 0", c, error, moved); end
    end
  endtask

  task automatic test_forward();
    logic [1:0] q;
    int pulses;
    set_quad(2'b00); button = 1'b0;
    do_reset();
    q = 2'b00; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      q = fwd_of(q);
      set_quad(q);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clock);
        if (moved === 1'b1) pulses++;
        checks++; if (moved !== (c == 3)) begin errors++; $display("FAIL fwd_moved_timing: step %0d cycle %0d got %b expected %b", i, c, moved, (c == 3)); end
        checks++; if (mouse_x !== 16'(c >= 3 ? i + 1 : i)) begin errors++; $display("FAIL fwd_mouse_x: step %0d cycle %0d got %0d expected %0d", i, c, mouse_x, (c >= 3 ? i + 1 : i)); end
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL fwd_pulse_count: got %0d expected 4", pulses); end
  endtask

  task automatic test_clamp();
    logic [1:0] q;
    int pulses;
    set_quad(2'b00); button = 1'b0;
    do_reset();
    q = 2'b00; pulses = 0;
    for (int i = 0; i < 3; i++) begin
      q = rev_of(q); set_quad(q);
      repeat (3) begin @(negedge clock); if (moved_s === 1'b1) pulses++; end
    end
    checks++; if (mouse_x_s !== 16'd0) begin errors++; $display("FAIL clamp_low_x: got %0d expected 0", mouse_x_s); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL clamp_low_pulses: got %0d expected 0", pulses); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      q = fwd_of(q); set_quad(q);
      repeat (3) begin @(negedge clock); if (moved_s === 1'b1) pulses++; end
    end
    checks++; if (mouse_x_s !== 16'd3) begin errors++; $display("FAIL clamp_high_x: got %0d expected 3", mouse_x_s); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL clamp_high_pulses: got %0d expected 3", pulses); end
    checks++; if (mouse_x !== 16'd5) begin errors++; $display("FAIL clamp_wide_x: got %0d expected 5", mouse_x); end
  endtask

  task automatic test_illegal();
    logic [1:0] q;
    set_quad(2'b00); button = 1'b0;
    do_reset();
    q = 2'b00;
    for (int i = 0; i < 4; i++) begin
      q = fwd_of(q); set_quad(q);
      repeat (3) @(negedge clock);
    end
    set_quad(2'b11);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      checks++; if (error !== (c >= 3)) begin errors++; $display("FAIL illegal_error: cycle %0d got %b expected %b", c, error, (c >= 3)); end
    end
    checks++; if (mouse_x !== 16'd4 || moved !== 1'b0) begin errors++; $display("FAIL illegal_hold_x: got x=%0d moved=%b expected 4 0", mouse_x, moved); end
    set_quad(2'b01);
    repeat (3) @(negedge clock);
    checks++; if (mouse_x !== 16'd3 || moved !== 1'b1) begin errors++; $display("FAIL illegal_then_rev: got x=%0d moved=%b expected 3 1", mouse_x, moved); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", error); end
  endtask

  task automatic test_debounce();
    set_quad(2'b00); button = 1'b0;
    do_reset();
    button = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++; if (mouse_pressed_ !== 1'b0) begin errors++; $display("FAIL bounce_glitch_hi: got %b expected 0", mouse_pressed_); end
    end
    button = 1'b0;
    @(negedge clock);
    checks++; if (mouse_pressed_ !== 1'b0) begin errors++; $display("FAIL bounce_glitch_lo: got %b expected 0", mouse_pressed_); end
    button = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      checks++; if (mouse_pressed_ !== (c >= 6)) begin errors++; $display("FAIL debounce_rise: edge k+%0d got %b expected %b", c - 1, mouse_pressed_, (c >= 6)); end
    end
    button = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      checks++; if (mouse_pressed_ !== (c < 6)) begin errors++; $display("FAIL debounce_fall: edge k+%0d got %b expected %b", c - 1, mouse_pressed_, (c < 6)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] q;
    set_quad(2'b00); button = 1'b0;
    do_reset();
    button = 1'b1;
    q = rev_of(2'b00); set_quad(q);
    repeat (3) @(negedge clock);
    q = 2'b01; set_quad(q);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      q = fwd_of(q); set_quad(q);
      repeat (3) @(negedge clock);
    end
    checks++; if (mouse_x !== 16'd5 || error !== 1'b1 || mouse_pressed_ !== 1'b1) begin errors++; $display("FAIL midreset_setup: got x=%0d error=%b pressed=%b expected 5 1 1", mouse_x, error, mouse_pressed_); end
    reset_ = 1'b1;
    @(negedge clock);
    reset_ = 1'b0;
    checks++; if (mouse_x !== 16'd0 || error !== 1'b0 || moved !== 1'b0 || mouse_pressed_ !== 1'b0) begin errors++; $display("FAIL midreset_values: got x=%0d error=%b moved=%b pressed=%b expected 0 0 0 0", mouse_x, error, moved, mouse_pressed_); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      checks++; if (error !== 1'b0 || mouse_x !== 16'd0) begin errors++; $display("FAIL midreset_rest: cycle %0d got error=%b x=%0d expected 0 0", c, error, mouse_x); end
    end
    set_quad(fwd_of(2'b11));
    repeat (3) @(negedge clock);
    checks++; if (mouse_x !== 16'd1 || moved !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL midreset_first_step: got x=%0d moved=%b error=%b expected 1 1 0", mouse_x, moved, error); end
  endtask

  task automatic test_simultaneous();
    set_quad(2'b00); button = 1'b0;
    do_reset();
    set_quad(2'b01);
    button = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      checks++; if (mouse_x !== 16'(c >= 3) || moved !== (c == 3)) begin errors++; $display("FAIL simul_quad: cycle %0d got x=%0d moved=%b expected %0d %b", c, mouse_x, moved, (c >= 3), (c == 3)); end
      checks++; if (mouse_pressed_ !== (c >= 6)) begin errors++; $display("FAIL simul_button: cycle %0d got %b expected %b", c, mouse_pressed_, (c >= 6)); end
    end
  endtask

  task automatic test_random();
    logic [1:0] q;
    int r, hold;
    set_quad(2'b00); button = 1'b0;
    do_reset();
    q = 2'b00;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      q = fwd_of(q);
      else if (r < 80) q = rev_of(q);
      else if (r < 86) q = q ^ 2'b11;
      set_quad(q);
      if ($urandom_range(0, 2) == 0) button = ~button;
      hold = $urandom_range(1, 4);
      repeat (hold) begin
        @(negedge clock);
        checks++; if (mouse_x !== 16'(m_x)) begin errors++; $display("FAIL rand_x: iter %0d got %0d expected %0d", it, mouse_x, m_x); end
        checks++; if (moved !== m_moved) begin errors++; $display("FAIL rand_moved: iter %0d got %b expected %b", it, moved, m_moved); end
        checks++; if (error !== m_err || error_s !== m_err) begin errors++; $display("FAIL rand_error: iter %0d got %b/%b expected %b", it, error, error_s, m_err); end
        checks++; if (mouse_pressed_ !== m_pressed || pressed_s !== m_pressed) begin errors++; $display("FAIL rand_pressed: iter %0d got %b/%b expected %b", it, mouse_pressed_, pressed_s, m_pressed); end
        checks++; if (mouse_x_s !== 16'(m_xs) || moved_s !== m_moved_s) begin errors++; $display("FAIL rand_small: iter %0d got x=%0d moved=%b expected %0d %b", it, mouse_x_s, moved_s, m_xs, m_moved_s); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_clamp();
    test_illegal();
    test_debounce();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
